lcd_display_driver: RTL and testbench

//  Consumes the character-mapped DisplayBuffer exported by the data memory (MEMTYPE=1 store region).

---
 rtl/lcd_pkg.sv | 44 ++++
 rtl/lcd_display_driver_write.sv | 90 +++++++++
 rtl/lcd_display_driver.sv | 192 +++++++++++++++++++
 tb/tb_lcd_display_driver.sv | 433 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command bytes and helpers for the character LCD driver.
// Optional feature macro: LCD_AUTO_REFRESH_EN (used in lcd_display_driver).
package lcd_pkg;

    typedef enum logic [2:0] {
        S_PWRON,
        S_INIT,
        S_IDLE,
        S_SNAP,
        S_ADDR,
        S_CHAR,
        S_DONE
    } lcd_state_e;

    typedef enum logic [1:0] {
        WC_IDLE,
        WC_SETUP,
        WC_PULSE,
        WC_DELAY
    } wc_phase_e;

    localparam logic [7:0] LCD_FUNC_SET  = 8'h38;
    localparam logic [7:0] LCD_DISP_ON   = 8'h0C;
    localparam logic [7:0] LCD_ENTRY     = 8'h06;
    localparam logic [7:0] LCD_CLEAR     = 8'h01;
    localparam logic [7:0] LCD_SET_DDRAM = 8'h80;
    localparam logic [6:0] LCD_LINE2     = 7'h40;
    localparam logic [7:0] LCD_SPACE     = 8'h20;

    // Non-printable bytes would show as CGRAM glyphs or garbage; blank them.
    function automatic logic [7:0] lcd_filter(input logic [7:0] b);
        return ((b < 8'h20) || (b > 8'h7E)) ? LCD_SPACE : b;
    endfunction

    function automatic logic [7:0] lcd_init_cmd(input logic [1:0] idx);
        case (idx)
            2'd0:    return LCD_FUNC_SET;
            2'd1:    return LCD_DISP_ON;
            2'd2:    return LCD_ENTRY;
            default: return LCD_CLEAR;
        endcase
    endfunction

endpackage

// File: rtl/lcd_display_driver_write.sv
// One HD44780 bus write: setup cycle, enable pulse, then a post-write delay.
// Owns the registered LCD bus pins; done_o marks the final delay cycle.
module lcd_write_cycle
    import lcd_pkg::*;
#(
    parameter int unsigned EnablePulseCycles = 12,
    parameter int unsigned CmdDelayCycles    = 2500,
    parameter int unsigned ClearDelayCycles  = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_i,
    input  logic [7:0] data_i,
    input  logic       rs_i,
    input  logic       long_delay_i,
    output logic       done_o,
    output logic [7:0] lcd_data_o,
    output logic       lcd_rs_o,
    output logic       lcd_en_o
);

    localparam int unsigned MaxDelay  = (CmdDelayCycles > ClearDelayCycles) ? CmdDelayCycles : ClearDelayCycles;
    localparam int unsigned MaxCycles = (EnablePulseCycles > MaxDelay) ? EnablePulseCycles : MaxDelay;
    localparam int unsigned CW        = $clog2(MaxCycles + 1);

    localparam logic [CW-1:0] EnLim  = CW'(EnablePulseCycles);
    localparam logic [CW-1:0] CmdLim = CW'(CmdDelayCycles);
    localparam logic [CW-1:0] ClrLim = CW'(ClearDelayCycles);

    wc_phase_e     phase_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] delay_lim;
    logic [7:0]    data_q;
    logic          rs_q;
    logic          en_q;
    logic          long_q;

    assign delay_lim  = long_q ? ClrLim : CmdLim;
    assign done_o     = (phase_q == WC_DELAY) && (cnt_q >= delay_lim);
    assign lcd_data_o = data_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_en_o   = en_q;

    // Counters only advance while below their limit, so they never wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= WC_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            rs_q    <= 1'b0;
            en_q    <= 1'b0;
            long_q  <= 1'b0;
        end else begin
            unique case (phase_q)
                WC_IDLE: begin
                    if (start_i) begin
                        data_q  <= data_i;
                        rs_q    <= rs_i;
                        long_q  <= long_delay_i;
                        phase_q <= WC_SETUP;
                    end
                end
                WC_SETUP: begin
                    en_q    <= 1'b1;
                    cnt_q   <= CW'(1);
                    phase_q <= WC_PULSE;
                end
                WC_PULSE: begin
                    if (cnt_q >= EnLim) begin
                        en_q    <= 1'b0;
                        cnt_q   <= CW'(1);
                        phase_q <= WC_DELAY;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                WC_DELAY: begin
                    if (cnt_q >= delay_lim) begin
                        cnt_q   <= '0;
                        phase_q <= WC_IDLE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: phase_q <= WC_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_display_driver.sv
// HD44780 16x2 driver: power-on wait, init sequence, then one snapshot frame per request.
// Optional feature macro: LCD_AUTO_REFRESH_EN (start a frame when the buffer differs from the snapshot).
module lcd_display_driver
    import lcd_pkg::*;
#(
    parameter int unsigned DisplayBufferSize = 256,
    parameter int unsigned PowerOnCycles     = 750000,
    parameter int unsigned EnablePulseCycles = 12,
    parameter int unsigned CmdDelayCycles    = 2500,
    parameter int unsigned ClearDelayCycles  = 100000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [DisplayBufferSize-1:0] DisplayBuffer,
    input  logic                         Refresh,
    output logic [7:0]                   LcdData,
    output logic                         LcdRs,
    output logic                         LcdRw,
    output logic                         LcdEn,
    output logic                         Busy,
    output logic                         FrameDone
);

    localparam int unsigned   NumChars = DisplayBufferSize / 8;
    localparam int unsigned   PW       = $clog2(PowerOnCycles + 1);
    localparam logic [PW-1:0] PonLast  = PW'(PowerOnCycles - 1);
    localparam logic [4:0]    LastChar = 5'(NumChars - 1);

`ifdef LCD_AUTO_REFRESH_EN
    localparam logic [DisplayBufferSize-1:0] SnapReset = {NumChars{LCD_SPACE}};
`else
    localparam logic [DisplayBufferSize-1:0] SnapReset = '0;
`endif

    lcd_state_e                   state_q;
    logic [PW-1:0]                pwr_cnt_q;
    logic [1:0]                   step_q;
    logic [4:0]                   char_idx_q;
    logic                         issued_q;
    logic                         start_q;
    logic [7:0]                   wr_data_q;
    logic                         wr_rs_q;
    logic                         wr_long_q;
    logic                         pending_q;
    logic                         busy_q;
    logic                         frame_done_q;
    logic [DisplayBufferSize-1:0] snap_q;

    logic       wr_done;
    logic       auto_trig;
    logic [7:0] cur_char;
    logic [7:0] cmd_data;
    logic       cmd_rs;
    logic       cmd_long;

`ifdef LCD_AUTO_REFRESH_EN
    logic diff_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            diff_q <= 1'b0;
        end else begin
            diff_q <= (DisplayBuffer != snap_q);
        end
    end

    assign auto_trig = diff_q;
`else
    assign auto_trig = 1'b0;
`endif

    always_comb begin
        cur_char = LCD_SPACE;
        for (int unsigned k = 0; k < NumChars; k++) begin
            if (char_idx_q == 5'(k)) cur_char = snap_q[8*(NumChars-1-k) +: 8];
        end
    end

    always_comb begin
        cmd_data = LCD_SPACE;
        cmd_rs   = 1'b0;
        cmd_long = 1'b0;
        case (state_q)
            S_INIT: begin
                cmd_data = lcd_init_cmd(step_q);
                cmd_long = (step_q == 2'd3);
            end
            S_ADDR:  cmd_data = LCD_SET_DDRAM | (char_idx_q[4] ? {1'b0, LCD_LINE2} : 8'h00);
            S_CHAR: begin
                cmd_data = lcd_filter(cur_char);
                cmd_rs   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_PWRON;
            pwr_cnt_q    <= '0;
            step_q       <= '0;
            char_idx_q   <= '0;
            issued_q     <= 1'b0;
            start_q      <= 1'b0;
            wr_data_q    <= '0;
            wr_rs_q      <= 1'b0;
            wr_long_q    <= 1'b0;
            pending_q    <= 1'b0;
            busy_q       <= 1'b1;
            frame_done_q <= 1'b0;
            snap_q       <= SnapReset;
        end else begin
            start_q      <= 1'b0;
            frame_done_q <= 1'b0;
            // A request in S_SNAP merges into the snapshot taken on that same edge.
            if (Refresh && (state_q != S_IDLE) && (state_q != S_SNAP)) pending_q <= 1'b1;

            unique case (state_q)
                S_PWRON: begin
                    if (pwr_cnt_q >= PonLast) state_q <= S_INIT;
                    else                      pwr_cnt_q <= pwr_cnt_q + PW'(1);
                end
                S_INIT, S_ADDR, S_CHAR: begin
                    if (!issued_q) begin
                        issued_q  <= 1'b1;
                        start_q   <= 1'b1;
                        wr_data_q <= cmd_data;
                        wr_rs_q   <= cmd_rs;
                        wr_long_q <= cmd_long;
                    end else if (wr_done) begin
                        issued_q <= 1'b0;
                        if (state_q == S_INIT) begin
                            if (step_q == 2'd3) begin
                                state_q <= S_IDLE;
                                busy_q  <= 1'b0;
                            end else begin
                                step_q <= step_q + 2'd1;
                            end
                        end else if (state_q == S_ADDR) begin
                            state_q <= S_CHAR;
                        end else if (char_idx_q == LastChar) begin
                            state_q      <= S_DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            char_idx_q <= char_idx_q + 5'd1;
                            if (char_idx_q == 5'd15) state_q <= S_ADDR;
                        end
                    end
                end
                S_IDLE: begin
                    if (Refresh || pending_q || auto_trig) begin
                        state_q <= S_SNAP;
                        busy_q  <= 1'b1;
                    end
                end
                S_SNAP: begin
                    snap_q     <= DisplayBuffer;
                    pending_q  <= 1'b0;
                    char_idx_q <= '0;
                    state_q    <= S_ADDR;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_PWRON;
            endcase
        end
    end

    lcd_write_cycle #(
        .EnablePulseCycles (EnablePulseCycles),
        .CmdDelayCycles    (CmdDelayCycles),
        .ClearDelayCycles  (ClearDelayCycles)
    ) u_write (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_q),
        .data_i       (wr_data_q),
        .rs_i         (wr_rs_q),
        .long_delay_i (wr_long_q),
        .done_o       (wr_done),
        .lcd_data_o   (LcdData),
        .lcd_rs_o     (LcdRs),
        .lcd_en_o     (LcdEn)
    );

    assign LcdRw     = 1'b0;
    assign Busy      = busy_q;
    assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_lcd_display_driver.sv
// Scoreboard bench for lcd_display_driver: expected bus writes are queued with the stimulus
// and compared against writes captured on each falling edge of LcdEn.
module tb_lcd_display_driver;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] DisplayBuffer;
    logic         Refresh;
    logic [7:0]   LcdData;
    logic         LcdRs;
    logic         LcdRw;
    logic         LcdEn;
    logic         Busy;
    logic         FrameDone;

    always #5 clk = ~clk;

    lcd_display_driver #(
        .DisplayBufferSize (256),
        .PowerOnCycles     (10),
        .EnablePulseCycles (2),
        .CmdDelayCycles    (4),
        .ClearDelayCycles  (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .DisplayBuffer (DisplayBuffer),
        .Refresh       (Refresh),
        .LcdData       (LcdData),
        .LcdRs         (LcdRs),
        .LcdRw         (LcdRw),
        .LcdEn         (LcdEn),
        .Busy          (Busy),
        .FrameDone     (FrameDone)
    );

    typedef struct packed { logic rs; logic [7:0] data; } exp_t;
    typedef struct packed { logic rs; logic [7:0] data; logic [15:0] width; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   fd_count    = 0;
    int   rw_bad      = 0;
    logic en_prev     = 1'b0;
    int   en_width    = 0;

    always @(negedge clk) begin
        if (LcdEn === 1'b1) begin
            en_width++;
        end else begin
            if (en_prev === 1'b1) obs_q.push_back('{LcdRs, LcdData, 16'(en_width)});
            en_width = 0;
        end
        if (FrameDone === 1'b1) fd_count++;
        if (LcdRw !== 1'b0) rw_bad++;
        en_prev = LcdEn;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    function automatic logic [255:0] mk_buf(input string s);
        logic [255:0] v = '0;
        logic [7:0]   c;
        for (int i = 0; i < 32; i++) begin
            c = (i < s.len()) ? s[i] : 8'h20;
            v = {v[247:0], c};
        end
        return v;
    endfunction

    function automatic logic [255:0] set_byte(input logic [255:0] v, input int k, input logic [7:0] b);
        logic [255:0] m = 256'hFF << (8 * (31 - k));
        return (v & ~m) | ({248'b0, b} << (8 * (31 - k)));
    endfunction

    task automatic expect_init();
        exp_q.push_back('{1'b0, 8'h38});
        exp_q.push_back('{1'b0, 8'h0C});
        exp_q.push_back('{1'b0, 8'h06});
        exp_q.push_back('{1'b0, 8'h01});
    endtask

    task automatic expect_frame(input logic [255:0] b);
        logic [255:0] t;
        logic [7:0]   c;
        exp_q.push_back('{1'b0, 8'h80});
        for (int k = 0; k < 32; k++) begin
            if (k == 16) exp_q.push_back('{1'b0, 8'hC0});
            t = b >> (8 * (31 - k));
            c = t[7:0];
            if (c < 8'h20 || c > 8'h7E) c = 8'h20;
            exp_q.push_back('{1'b1, c});
        end
    endtask

    task automatic wait_obs(input int n, input int budget, output bit ok);
        int t = 0;
        @(negedge clk);
        while (obs_q.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        ok = (obs_q.size() >= n);
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        Refresh = 1'b1;
        @(negedge clk);
        Refresh = 1'b0;
    endtask

    task automatic test_reset();
        bit ok;
        int t;
        repeat (3) @(negedge clk);
        vectors++;
        if ({LcdEn, Busy, FrameDone, LcdRs, LcdRw, LcdData} !== 13'b0_1_0_0_0_00000000) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b busy=%b fd=%b rs=%b rw=%b data=%h, want 0 1 0 0 0 00",
                     LcdEn, Busy, FrameDone, LcdRs, LcdRw, LcdData);
        end
        rst_n = 1'b1;
        obs_q.delete();
        exp_q.delete();
        expect_init();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++;
            if (LcdEn !== 1'b0) begin
                miscompares++;
                $display("FAIL pwron_en[%0d]: got %b, want 0", i, LcdEn);
            end
        end
        wait_obs(4, 400, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL init_timeout: got %0d writes, want 4", obs_q.size());
            obs_q.delete();
            exp_q.delete();
            return;
        end
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.rs !== e.rs || o.data !== e.data || o.width !== 16'd2) begin
                miscompares++;
                $display("FAIL init[%0d]: got rs=%b data=%h en=%0d, want rs=%b data=%h en=2",
                         i, o.rs, o.data, o.width, e.rs, e.data);
            end
        end
        t = 0;
        while (Busy !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        vectors++;
        if (Busy !== 1'b0 || t < 6 || t > 9) begin
            miscompares++;
            $display("FAIL clear_delay: got busy=%b after %0d cycles, want busy=0 after 6..9", Busy, t);
        end
    endtask

    task automatic test_frame();
        bit ok;
        int fd0 = fd_count;
        int rw0 = rw_bad;
        @(negedge clk);
        DisplayBuffer = mk_buf("HELLO           0123456789ABCDEF");
        Refresh = 1'b1;
        expect_frame(DisplayBuffer);
        @(negedge clk);
        Refresh = 1'b0;
        wait_obs(34, 2000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL frame_timeout: got %0d writes, want 34", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 34; i++) begin
                exp_t e;
                obs_t o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                vectors++;
                if (o.rs !== e.rs || o.data !== e.data || o.width !== 16'd2) begin
                    miscompares++;
                    $display("FAIL frame[%0d]: got rs=%b data=%h en=%0d, want rs=%b data=%h en=2",
                             i, o.rs, o.data, o.width, e.rs, e.data);
                end
            end
        end
        repeat (20) @(negedge clk);
        vectors++;
        if (fd_count - fd0 != 1 || rw_bad != rw0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL frame_end: got framedone=%0d rw_errs=%0d busy=%b, want 1 0 0",
                     fd_count - fd0, rw_bad - rw0, Busy);
        end
    endtask

    task automatic test_no_tearing();
        bit ok;
        int fd0 = fd_count;
        logic [255:0] a = mk_buf("abcdefghijklmnopqrstuvwxyz012345");
        logic [255:0] b = mk_buf("ZYXWVUTSRQPONMLKJIHGFEDCBA987654");
        @(negedge clk);
        DisplayBuffer = a;
        Refresh = 1'b1;
        expect_frame(a);
        @(negedge clk);
        Refresh = 1'b0;
        wait_obs(6, 2000, ok);
        DisplayBuffer = b;
        expect_frame(b);
        pulse_refresh();
        repeat (20) @(negedge clk);
        pulse_refresh();
        wait_obs(68, 5000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL tearing_timeout: got %0d writes, want 68", obs_q.size());
            obs_q.delete();
            exp_q.delete();
        end else begin
            for (int i = 0; i < 68; i++) begin
                exp_t e;
                obs_t o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                vectors++;
                if (o.rs !== e.rs || o.data !== e.data) begin
                    miscompares++;
                    $display("FAIL tearing[%0d]: got rs=%b data=%h, want rs=%b data=%h",
                             i, o.rs, o.data, e.rs, e.data);
                end
            end
        end
        repeat (600) @(negedge clk);
        vectors++;
        if (obs_q.size() != 0 || fd_count - fd0 != 2) begin
            miscompares++;
            $display("FAIL pending_merge: got extra_writes=%0d frames=%0d, want 0 2",
                     obs_q.size(), fd_count - fd0);
            obs_q.delete();
        end
    endtask

    task automatic test_filter();
        bit ok;
        logic [255:0] v = mk_buf("ABCDEFGHIJKLMNOPQRSTUVWXYZ[]^_`{");
        v = set_byte(v, 3, 8'h07);
        v = set_byte(v, 9, 8'h80);
        v = set_byte(v, 12, 8'h7E);
        v = set_byte(v, 20, 8'h1F);
        v = set_byte(v, 21, 8'h7F);
        v = set_byte(v, 30, 8'h20);
        v = set_byte(v, 31, 8'hFF);
        @(negedge clk);
        DisplayBuffer = v;
        Refresh = 1'b1;
        expect_frame(v);
        @(negedge clk);
        Refresh = 1'b0;
        wait_obs(34, 2000, ok);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL filter_timeout: got %0d writes, want 34", obs_q.size());
            obs_q.delete();
            exp_q.delete();
            return;
        end
        for (int i = 0; i < 34; i++) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.rs !== e.rs || o.data !== e.data) begin
                miscompares++;
                $display("FAIL filter[%0d]: got rs=%b data=%h, want rs=%b data=%h",
                         i, o.rs, o.data, e.rs, e.data);
            end
        end
        repeat (20) @(negedge clk);
    endtask

    task automatic test_reset_midframe();
        bit ok;
        @(negedge clk);
        DisplayBuffer = mk_buf("Reset mid frame 0123456789abcdef");
        Refresh = 1'b1;
        @(negedge clk);
        Refresh = 1'b0;
        wait_obs(11, 2000, ok);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (!ok || LcdEn !== 1'b0 || Busy !== 1'b1 || FrameDone !== 1'b0 || LcdData !== 8'h00) begin
            miscompares++;
            $display("FAIL midframe_reset: got reached=%0b en=%b busy=%b fd=%b data=%h, want 1 0 1 0 00",
                     ok, LcdEn, Busy, FrameDone, LcdData);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs_q.delete();
        exp_q.delete();
        expect_init();
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            vectors++;
            if (LcdEn !== 1'b0) begin
                miscompares++;
                $display("FAIL repwron_en[%0d]: got %b, want 0", i, LcdEn);
            end
        end
`ifdef LCD_AUTO_REFRESH_EN
        expect_frame(DisplayBuffer);
        wait_obs(38, 3000, ok);
`else
        wait_obs(4, 400, ok);
`endif
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL reinit_timeout: got %0d writes, want %0d", obs_q.size(), exp_q.size());
            obs_q.delete();
            exp_q.delete();
            return;
        end
        while (exp_q.size() != 0) begin
            exp_t e;
            obs_t o;
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            vectors++;
            if (o.rs !== e.rs || o.data !== e.data) begin
                miscompares++;
                $display("FAIL reinit: got rs=%b data=%h, want rs=%b data=%h", o.rs, o.data, e.rs, e.data);
            end
        end
        repeat (30) @(negedge clk);
        vectors++;
        if (Busy !== 1'b0 || obs_q.size() != 0) begin
            miscompares++;
            $display("FAIL reinit_idle: got busy=%b extra_writes=%0d, want 0 0", Busy, obs_q.size());
            obs_q.delete();
        end
    endtask

    task automatic test_auto();
        int fd0;
        logic [7:0] nb;
        repeat (10) @(negedge clk);
        fd0 = fd_count;
        nb = (DisplayBuffer[7:0] == 8'h41) ? 8'h42 : 8'h41;
        DisplayBuffer[7:0] = nb;
`ifdef LCD_AUTO_REFRESH_EN
        begin
            bit ok;
            int t = 0;
            while (Busy !== 1'b1 && t < 5) begin
                @(negedge clk);
                t++;
            end
            vectors++;
            if (Busy !== 1'b1 || t > 3) begin
                miscompares++;
                $display("FAIL auto_start: got busy=%b after %0d cycles, want busy=1 within 3", Busy, t);
            end
            expect_frame(DisplayBuffer);
            wait_obs(34, 2000, ok);
            vectors++;
            if (!ok) begin
                miscompares++;
                $display("FAIL auto_timeout: got %0d writes, want 34", obs_q.size());
                obs_q.delete();
                exp_q.delete();
                return;
            end
            for (int i = 0; i < 34; i++) begin
                exp_t e;
                obs_t o;
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                vectors++;
                if (o.rs !== e.rs || o.data !== e.data) begin
                    miscompares++;
                    $display("FAIL auto[%0d]: got rs=%b data=%h, want rs=%b data=%h",
                             i, o.rs, o.data, e.rs, e.data);
                end
            end
        end
`else
        repeat (100) @(negedge clk);
        vectors++;
        if (Busy !== 1'b0 || obs_q.size() != 0 || fd_count != fd0) begin
            miscompares++;
            $display("FAIL no_auto: got busy=%b writes=%0d frames=%0d, want 0 0 0",
                     Busy, obs_q.size(), fd_count - fd0);
        end
`endif
    endtask

    initial begin
        rst_n         = 1'b0;
        Refresh       = 1'b0;
        DisplayBuffer = {32{8'h20}};
        test_reset();
        test_frame();
        test_no_tearing();
        test_filter();
        test_reset_midframe();
        test_auto();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
